// File: rtl/sdram_cmd_phy.sv
// SDRAM command back end: registers scheduler commands onto the pins, drives write bursts,
// and captures CAS-delayed read data as tagged beats. Op codes: NOP0 REF1 PRE2 ACT3 WR4 RD5 MRS7.
module sdram_cmd_phy #(
    parameter int CAS   = 2,
    parameter int BURST = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    input  logic [33:0] cmd,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic [2:0]  rd_tag,
    output logic        rd_last,
    output logic        err,
    output logic        sd_cke,
    output logic        sd_cs_n,
    output logic        sd_ras_n,
    output logic        sd_cas_n,
    output logic        sd_we_n,
    output logic [1:0]  sd_ba,
    output logic [12:0] sd_a,
    output logic [1:0]  sd_dqm,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    input  logic [15:0] sd_dq_in
);
    localparam logic [2:0] OP_NOP = 3'h0, OP_REF = 3'h1, OP_PRE = 3'h2, OP_ACT = 3'h3;
    localparam logic [2:0] OP_WR  = 3'h4, OP_RD  = 3'h5, OP_BAD = 3'h6, OP_MRS = 3'h7;
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic                   s1_v_q, s1_v_d;
    logic [33:0]            s1_cmd_q, s1_cmd_d;
    logic                   cke_q, cke_d;
    logic [3:0]             pins_q, pins_d;
    logic [1:0]             ba_q, ba_d, dqm_q, dqm_d;
    logic [12:0]            a_q, a_d;
    logic [15:0]            dqo_q, dqo_d;
    logic                   oe_q, oe_d, err_q, err_d;
    logic [CW-1:0]          wr_left_q, wr_left_d, rd_left_q, rd_left_d;
    logic [CAS-1:0]         rp_v_q, rp_v_d;
    logic [CAS-1:0][2:0]    rp_tag_q, rp_tag_d;
    logic [2:0]             cur_tag_q, cur_tag_d, in_tag_q, in_tag_d, rdt_q, rdt_d;
    logic                   in_v_q, in_v_d, in_last_q, in_last_d;
    logic [15:0]            in_data_q, in_data_d, rdd_q, rdd_d;
    logic                   rdv_q, rdv_d, rdl_q, rdl_d;

    logic [2:0]  op;
    logic [15:0] data;
    logic        is_wr, is_rd, wr_busy, rd_pend, beat;

    assign op      = s1_cmd_q[33:31];
    assign data    = s1_cmd_q[15:0];
    assign is_wr   = s1_v_q && (op == OP_WR);
    assign is_rd   = s1_v_q && (op == OP_RD);
    assign wr_busy = (wr_left_q != '0);
    // Any beat still to be sampled from this edge onward, queued or mid-burst.
    assign rd_pend = (|rp_v_q) || (rd_left_q != '0);

    always_comb begin
        s1_v_d    = cmd_valid;
        s1_cmd_d  = cmd;
        cke_d     = 1'b1;
        pins_d    = 4'b1111;
        ba_d      = ba_q;
        a_d       = a_q;
        dqm_d     = 2'b11;
        dqo_d     = dqo_q;
        oe_d      = 1'b0;
        err_d     = err_q;
        wr_left_d = wr_left_q;
        rp_v_d    = '0;
        rp_tag_d  = rp_tag_q;
        rd_left_d = rd_left_q;
        cur_tag_d = cur_tag_q;
        in_v_d    = 1'b0;
        in_data_d = in_data_q;
        in_tag_d  = in_tag_q;
        in_last_d = 1'b0;
        rdv_d     = in_v_q;
        rdd_d     = in_v_q ? in_data_q : rdd_q;
        rdt_d     = in_v_q ? in_tag_q : rdt_q;
        rdl_d     = in_v_q & in_last_q;
        beat      = 1'b0;

        if (s1_v_q) begin
            case (op)
                OP_REF:  pins_d = 4'b0001;
                OP_PRE:  pins_d = 4'b0010;
                OP_ACT:  pins_d = 4'b0011;
                OP_WR:   pins_d = 4'b0100;
                OP_RD:   pins_d = 4'b0101;
                OP_MRS:  pins_d = 4'b0000;
                OP_BAD:  err_d  = 1'b1;
                default: pins_d = 4'b1111;
            endcase
            if (op != OP_NOP && op != OP_BAD) begin
                ba_d = s1_cmd_q[30:29];
                a_d  = (op == OP_MRS) ? data[12:0] : s1_cmd_q[28:16];
            end
        end
        if ((is_wr || is_rd) && wr_busy) err_d = 1'b1;
        if (is_wr && rd_pend)            err_d = 1'b1;

        // Write beats: a missing command during a burst still consumes its beat, masked.
        if (is_wr) begin
            wr_left_d = LAST_BEAT;
            beat      = 1'b1;
        end else if (wr_busy) begin
            wr_left_d = wr_left_q - ONE;
            if (is_rd) begin
                wr_left_d = '0;
            end else begin
                oe_d = 1'b1;
                beat = s1_v_q;
            end
        end
        if (beat) begin
            oe_d  = 1'b1;
            dqo_d = data;
        end

        rp_v_d[0]   = is_rd;
        rp_tag_d[0] = data[2:0];
        for (int i = 1; i < CAS; i++) begin
            rp_v_d[i]   = rp_v_q[i-1];
            rp_tag_d[i] = rp_tag_q[i-1];
        end
        // A newly arriving burst start overrides the remainder of an older one.
        if (rp_v_q[CAS-1]) begin
            in_v_d    = 1'b1;
            in_tag_d  = rp_tag_q[CAS-1];
            in_last_d = (BURST == 1);
            rd_left_d = LAST_BEAT;
            cur_tag_d = rp_tag_q[CAS-1];
        end else if (rd_left_q != '0) begin
            in_v_d    = 1'b1;
            in_tag_d  = cur_tag_q;
            in_last_d = (rd_left_q == ONE);
            rd_left_d = rd_left_q - ONE;
        end
        if (is_wr) begin
            rp_v_d    = '0;
            rd_left_d = '0;
            in_v_d    = 1'b0;
            in_last_d = 1'b0;
        end
        if (in_v_d) in_data_d = sd_dq_in;
        if (beat || rd_pend || is_rd) dqm_d = 2'b00;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_v_q    <= 1'b0;
            s1_cmd_q  <= '0;
            cke_q     <= 1'b0;
            pins_q    <= 4'b1111;
            ba_q      <= '0;
            a_q       <= '0;
            dqm_q     <= 2'b11;
            dqo_q     <= '0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            wr_left_q <= '0;
            rp_v_q    <= '0;
            rp_tag_q  <= '0;
            rd_left_q <= '0;
            cur_tag_q <= '0;
            in_v_q    <= 1'b0;
            in_data_q <= '0;
            in_tag_q  <= '0;
            in_last_q <= 1'b0;
            rdv_q     <= 1'b0;
            rdd_q     <= '0;
            rdt_q     <= '0;
            rdl_q     <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_cmd_q  <= s1_cmd_d;
            cke_q     <= cke_d;
            pins_q    <= pins_d;
            ba_q      <= ba_d;
            a_q       <= a_d;
            dqm_q     <= dqm_d;
            dqo_q     <= dqo_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
            wr_left_q <= wr_left_d;
            rp_v_q    <= rp_v_d;
            rp_tag_q  <= rp_tag_d;
            rd_left_q <= rd_left_d;
            cur_tag_q <= cur_tag_d;
            in_v_q    <= in_v_d;
            in_data_q <= in_data_d;
            in_tag_q  <= in_tag_d;
            in_last_q <= in_last_d;
            rdv_q     <= rdv_d;
            rdd_q     <= rdd_d;
            rdt_q     <= rdt_d;
            rdl_q     <= rdl_d;
        end
    end

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = pins_q;
    assign sd_cke    = cke_q;
    assign sd_ba     = ba_q;
    assign sd_a      = a_q;
    assign sd_dqm    = dqm_q;
    assign sd_dq_out = dqo_q;
    assign sd_dq_oe  = oe_q;
    assign err       = err_q;
    assign rd_valid  = rdv_q;
    assign rd_data   = rdd_q;
    assign rd_tag    = rdt_q;
    assign rd_last   = rdl_q;
endmodule

// File: tb/tb_sdram_cmd_phy.sv
// Drives a CAS=2 and a CAS=3 instance with identical commands and checks every pin and
// read beat against a per-edge model built from the command rules and a read-slot timeline.
module tb_sdram_cmd_phy;
    localparam int BURST = 8;
    localparam int MAXE  = 4096;
    localparam logic [2:0] OP_NOP = 3'h0, OP_REF = 3'h1, OP_PRE = 3'h2, OP_ACT = 3'h3;
    localparam logic [2:0] OP_WR  = 3'h4, OP_RD  = 3'h5, OP_BAD = 3'h6, OP_MRS = 3'h7;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [1:0]  dqm;
        logic [15:0] dqo;
        logic        oe;
        logic        err;
    } pin_t;
    localparam pin_t PIN_RST = '{cmd: 4'hf, ba: 2'd0, a: 13'd0, dqm: 2'b11, dqo: 16'd0, oe: 1'b0, err: 1'b0};

    logic clk = 1'b0, n_reset = 1'b0, cmd_valid = 1'b0;
    logic [33:0] cmd = '0;
    logic [15:0] sd_dq_in = '0;
    logic [1:0] rd_valid, rd_last, err, cke, cs_n, ras_n, cas_n, we_n, oe;
    logic [1:0][15:0] rd_data, dqo;
    logic [1:0][2:0]  rd_tag;
    logic [1:0][1:0]  ba, dqm;
    logic [1:0][12:0] a;

    always #5 clk = ~clk;

    sdram_cmd_phy #(.CAS(2), .BURST(BURST)) u_c2 (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_tag(rd_tag[0]), .rd_last(rd_last[0]),
        .err(err[0]), .sd_cke(cke[0]), .sd_cs_n(cs_n[0]), .sd_ras_n(ras_n[0]),
        .sd_cas_n(cas_n[0]), .sd_we_n(we_n[0]), .sd_ba(ba[0]), .sd_a(a[0]), .sd_dqm(dqm[0]),
        .sd_dq_out(dqo[0]), .sd_dq_oe(oe[0]), .sd_dq_in(sd_dq_in));

    sdram_cmd_phy #(.CAS(3), .BURST(BURST)) u_c3 (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_tag(rd_tag[1]), .rd_last(rd_last[1]),
        .err(err[1]), .sd_cke(cke[1]), .sd_cs_n(cs_n[1]), .sd_ras_n(ras_n[1]),
        .sd_cas_n(cas_n[1]), .sd_we_n(we_n[1]), .sd_ba(ba[1]), .sd_a(a[1]), .sd_dqm(dqm[1]),
        .sd_dq_out(dqo[1]), .sd_dq_oe(oe[1]), .sd_dq_in(sd_dq_in));

    // ex[d][e]: expected pins after edge e; sv/stag/slast[d][e]: read beat sampled at edge e.
    pin_t        ex[2][MAXE];
    bit          sv[2][MAXE];
    logic [2:0]  stag[2][MAXE];
    bit          slast[2][MAXE];
    logic [15:0] dqh[MAXE];
    int          wr_left[2];
    int          ecnt = 0, npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s @edge %0d: got %0h exp %0h", tag, ecnt, got, exp);
    endtask

    function automatic logic [33:0] mk(input logic [2:0] op, input logic [1:0] b,
                                       input logic [12:0] ad, input logic [15:0] dt);
        return {op, b, ad, dt};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            wr_left[d] = 0;
            ex[d][ecnt] = PIN_RST;
            for (int e = 0; e < MAXE; e++) sv[d][e] = 1'b0;
        end
    endtask

    // Command sitting in the input stage at edge k determines the pins after edge k+1.
    task automatic model_accept(input int k, input logic v, input logic [33:0] c);
        logic [2:0] op;
        pin_t p;
        bit rd, wr, pend, beat, win;
        int cas;
        op = c[33:31];
        for (int d = 0; d < 2; d++) begin
            cas = 2 + d;
            p = ex[d][k];
            rd = v && (op == OP_RD);
            wr = v && (op == OP_WR);
            pend = 1'b0;
            for (int e = k + 1; e < k + BURST + 8; e++) pend |= sv[d][e];
            p.cmd = 4'hf;
            if (v) begin
                case (op)
                    OP_REF: p.cmd = 4'b0001;
                    OP_PRE: p.cmd = 4'b0010;
                    OP_ACT: p.cmd = 4'b0011;
                    OP_WR:  p.cmd = 4'b0100;
                    OP_RD:  p.cmd = 4'b0101;
                    OP_MRS: p.cmd = 4'b0000;
                    OP_BAD: p.err = 1'b1;
                    default: ;
                endcase
                if (op != OP_NOP && op != OP_BAD) begin
                    p.ba = c[30:29];
                    p.a  = (op == OP_MRS) ? c[12:0] : c[28:16];
                end
            end
            if ((wr || rd) && wr_left[d] > 0) p.err = 1'b1;
            if (wr && pend) begin
                p.err = 1'b1;
                for (int e = k + 1; e < k + BURST + 8; e++) sv[d][e] = 1'b0;
            end
            beat = 1'b0;
            p.oe = 1'b0;
            if (wr) begin
                wr_left[d] = BURST - 1;
                beat = 1'b1;
            end else if (wr_left[d] > 0) begin
                wr_left[d]--;
                if (rd) wr_left[d] = 0;
                else begin
                    p.oe = 1'b1;
                    beat = v;
                end
            end
            if (beat) begin
                p.oe  = 1'b1;
                p.dqo = c[15:0];
            end
            if (rd) begin
                for (int i = 0; i < BURST; i++) begin
                    sv[d][k + 1 + cas + i]    = 1'b1;
                    stag[d][k + 1 + cas + i]  = c[2:0];
                    slast[d][k + 1 + cas + i] = (i == BURST - 1);
                end
            end
            win = 1'b0;
            for (int e = k + 1; e < k + BURST + 8; e++) win |= sv[d][e];
            p.dqm = (beat || win) ? 2'b00 : 2'b11;
            ex[d][k + 1] = p;
        end
    endtask

    task automatic check_now();
        int j;
        string nm;
        pin_t p;
        j = ecnt;
        for (int d = 0; d < 2; d++) begin
            nm = $sformatf("cas%0d", d + 2);
            p = ex[d][j];
            chk({nm, ".pins"}, 32'({cs_n[d], ras_n[d], cas_n[d], we_n[d]}), 32'(p.cmd));
            chk({nm, ".ba"},   32'(ba[d]),  32'(p.ba));
            chk({nm, ".a"},    32'(a[d]),   32'(p.a));
            chk({nm, ".dqm"},  32'(dqm[d]), 32'(p.dqm));
            chk({nm, ".dqo"},  32'(dqo[d]), 32'(p.dqo));
            chk({nm, ".oe"},   32'(oe[d]),  32'(p.oe));
            chk({nm, ".err"},  32'(err[d]), 32'(p.err));
            chk({nm, ".cke"},  32'(cke[d]), 32'd1);
            chk({nm, ".rd_valid"}, 32'(rd_valid[d]), 32'(sv[d][j-1]));
            chk({nm, ".rd_last"},  32'(rd_last[d]),  32'(sv[d][j-1] && slast[d][j-1]));
            if (sv[d][j-1]) begin
                chk({nm, ".rd_data"}, 32'(rd_data[d]), 32'(dqh[j-1]));
                chk({nm, ".rd_tag"},  32'(rd_tag[d]),  32'(stag[d][j-1]));
            end
        end
    endtask

    task automatic chk_rst();
        for (int d = 0; d < 2; d++) begin
            chk("rst.pins", 32'({cs_n[d], ras_n[d], cas_n[d], we_n[d]}), 32'hf);
            chk("rst.ba_a", 32'({ba[d], a[d]}), 32'd0);
            chk("rst.dqm", 32'(dqm[d]), 32'd3);
            chk("rst.dqo_oe", 32'({dqo[d], oe[d]}), 32'd0);
            chk("rst.cke_err", 32'({cke[d], err[d]}), 32'd0);
            chk("rst.rd", 32'({rd_valid[d], rd_last[d], rd_tag[d], rd_data[d]}), 32'd0);
        end
    endtask

    // Called at a negedge: drive for the next edge, advance, then check.
    task automatic step(input logic v, input logic [33:0] c);
        cmd_valid = v;
        cmd = c;
        sd_dq_in = 16'($urandom);
        dqh[ecnt + 1] = sd_dq_in;
        model_accept(ecnt + 1, v, c);
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        check_now();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, mk(OP_NOP, 2'd0, 13'd0, 16'd0));
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        cmd_valid = 1'b0;
        cmd = '0;
        #1 chk_rst();
        repeat (2) begin
            @(posedge clk);
            ecnt++;
        end
        @(negedge clk);
        chk_rst();
        n_reset = 1'b1;
        model_reset();
        model_accept(ecnt, 1'b0, '0);
    endtask

    task automatic rstep();
        logic [2:0] op;
        int r;
        r = $urandom_range(0, 19);
        op = (r < 4) ? OP_RD : (r < 8) ? OP_WR : (r < 10) ? OP_PRE : (r < 12) ? OP_ACT :
             (r == 12) ? OP_REF : (r == 13) ? OP_MRS : OP_NOP;
        step($urandom_range(0, 9) < 7, mk(op, 2'($urandom), 13'($urandom), 16'($urandom)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        idle(2);
        step(1'b1, mk(OP_MRS, 2'd0, 13'h1abc, 16'h0023));
        idle(3);
        step(1'b1, mk(OP_WR,  2'd1, 13'd5, 16'h00a0));
        step(1'b1, mk(OP_NOP, 2'd0, 13'd0, 16'h00a1));
        step(1'b1, mk(OP_PRE, 2'd2, 13'd0, 16'h00a2));
        step(1'b0, mk(OP_NOP, 2'd0, 13'd0, 16'h00a3));
        step(1'b1, mk(OP_ACT, 2'd3, 13'h44, 16'h00a4));
        step(1'b1, mk(OP_NOP, 2'd0, 13'd0, 16'h00a5));
        step(1'b1, mk(OP_REF, 2'd0, 13'd0, 16'h00a6));
        step(1'b1, mk(OP_NOP, 2'd0, 13'd0, 16'h00a7));
        idle(3);
        step(1'b1, mk(OP_RD, 2'd0, 13'h10, 16'h0005));
        idle(14);
        step(1'b1, mk(OP_RD, 2'd1, 13'h20, 16'h0001));
        idle(3);
        step(1'b1, mk(OP_RD, 2'd1, 13'h28, 16'h0002));
        idle(16);
        step(1'b1, mk(OP_RD, 2'd0, 13'h30, 16'h0003));
        idle(5);
        do_reset();
        idle(4);
        step(1'b1, mk(OP_RD, 2'd0, 13'h30, 16'h0004));
        idle(1);
        step(1'b1, mk(OP_WR, 2'd0, 13'h31, 16'hbeef));
        idle(12);
        step(1'b1, mk(OP_BAD, 2'd0, 13'h0, 16'h0));
        idle(3);
        do_reset();
        idle(2);
        step(1'b1, mk(OP_BAD, 2'd0, 13'h0, 16'h0));
        idle(4);
        do_reset();
        for (int r = 0; r < 4; r++) begin
            repeat (400) rstep();
            do_reset();
            idle(2);
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
